// File: rtl/fdiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fdiv_pkg                                                       |
// | Purpose  : Shared types and defaults for the two-requester divider       |
// |            arbiter (FSM state encoding, requester id, operand width).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package fdiv_pkg;

  // Default operand/result width (IEEE-754 single precision).
  localparam int unsigned FDIV_WIDTH = 32;

  // Requester identifier: 0 or 1.
  typedef logic req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage : fdiv_pkg
`default_nettype wire

// File: rtl/fdiv_rr2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fdiv_rr2                                                       |
// | Purpose  : Two-way round-robin pick. A lone requester always wins; on a  |
// |            tie the requester that was not served last wins.              |
// | Ports    : valid_i[1:0]  request valid per requester                     |
// |            last_id_i     requester served most recently                  |
// |            grant_o[1:0]  one-hot grant (zero when nothing valid)         |
// |            gid_o         index of the granted requester                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fdiv_rr2
  import fdiv_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_id_t    last_id_i,
  output logic [1:0] grant_o,
  output req_id_t    gid_o
);

  always_comb begin
    gid_o   = 1'b0;
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   gid_o = 1'b0;
      2'b10:   gid_o = 1'b1;
      2'b11:   gid_o = ~last_id_i;
      default: gid_o = 1'b0;
    endcase
    if (valid_i != 2'b00) begin
      grant_o = gid_o ? 2'b10 : 2'b01;
    end
  end

endmodule : fdiv_rr2
`default_nettype wire

// File: rtl/fdiv_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fdiv_arbiter                                                   |
// | Purpose  : Shares one iterative FP divider between two requesters.       |
// |            Accepts one request at a time, drives the divider, waits for  |
// |            completion (or aborts after TIMEOUT cycles) and returns the   |
// |            quotient to the requester that issued it.                     |
// | Ports    : clk, rst (sync, active-low)                                   |
// |            req_valid_i/req_ready_o    request handshake per requester    |
// |            req{0,1}_{a,b}_i           dividend/divisor per requester     |
// |            rsp_valid_o/rsp_ready_i    response handshake per requester   |
// |            rsp_q_o, rsp_err_o         shared quotient, timeout flag      |
// |            div_a_o, div_b_o, div_start_o, div_enable_o  divider drive    |
// |            div_q_i, div_busy_i        divider result and status          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fdiv_arbiter
  import fdiv_pkg::*;
#(
  parameter int unsigned WIDTH   = FDIV_WIDTH,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [WIDTH-1:0] rsp_q_o,
  output logic             rsp_err_o,
  output logic [WIDTH-1:0] div_a_o,
  output logic [WIDTH-1:0] div_b_o,
  output logic             div_start_o,
  output logic             div_enable_o,
  input  logic [WIDTH-1:0] div_q_i,
  input  logic             div_busy_i
);

  localparam int unsigned           c_cnt_w   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0]    c_timeout = c_cnt_w'(TIMEOUT);

  state_e             state_q, state_d;
  req_id_t            id_q, id_d;
  req_id_t            last_id_q, last_id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  logic [1:0]         w_grant;
  req_id_t            w_gid;
  logic [1:0]         w_req_ready;
  logic [1:0]         w_rsp_valid;
  logic               w_div_start;

  fdiv_rr2 u_rr2 (
    .valid_i   (req_valid_i),
    .last_id_i (last_id_q),
    .grant_o   (w_grant),
    .gid_o     (w_gid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;  // requester 0 wins the first tie
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    w_req_ready = 2'b00;
    w_rsp_valid = 2'b00;
    w_div_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i != 2'b00) begin
          w_req_ready = w_grant;
          id_d        = w_gid;
          a_d         = w_gid ? req1_a_i : req0_a_i;
          b_d         = w_gid ? req1_b_i : req0_b_i;
          state_d     = ST_ISSUE;
        end
      end

      // Keep start asserted until the divider acknowledges by going busy.
      ST_ISSUE: begin
        w_div_start = 1'b1;
        if (div_busy_i) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      // Completion is tested before the timeout so a result that lands on
      // the last allowed cycle is still delivered.
      ST_WAIT: begin
        if (!div_busy_i) begin
          res_d   = div_q_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == c_timeout) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Only the owning requester's rsp_ready completes the response.
      ST_RESP: begin
        w_rsp_valid = id_q ? 2'b10 : 2'b01;
        if (rsp_ready_i[id_q]) begin
          last_id_d = id_q;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low combinationally while reset is held so they read
  // zero even before the first reset edge clears the registers.
  assign req_ready_o  = rst ? w_req_ready : 2'b00;
  assign rsp_valid_o  = rst ? w_rsp_valid : 2'b00;
  assign rsp_q_o      = rst ? res_q       : '0;
  assign rsp_err_o    = rst & err_q;
  assign div_a_o      = rst ? a_q         : '0;
  assign div_b_o      = rst ? b_q         : '0;
  assign div_start_o  = rst & w_div_start;
  assign div_enable_o = rst;

endmodule : fdiv_arbiter
`default_nettype wire

// File: tb/tb_fdiv_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fdiv_arbiter                                                |
// | Purpose  : Self-checking bench for fdiv_arbiter with a behavioural        |
// |            divider and a response scoreboard.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fdiv_arbiter;
  import fdiv_pkg::*;

  localparam int W   = 32;
  localparam int TMO = 63;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   rsp_ready = 2'b00;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]   req_ready, rsp_valid;
  logic [W-1:0] rsp_q, div_a, div_b, div_q;
  logic         rsp_err, div_start, div_enable, div_busy;

  always #5 clk = ~clk;

  fdiv_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_q_o      (rsp_q),
    .rsp_err_o    (rsp_err),
    .div_a_o      (div_a),
    .div_b_o      (div_b),
    .div_start_o  (div_start),
    .div_enable_o (div_enable),
    .div_q_i      (div_q),
    .div_busy_i   (div_busy)
  );

  // Known quotients of the operand pairs used below.
  function automatic logic [W-1:0] div_model(input logic [W-1:0] a, input logic [W-1:0] b);
    case ({a, b})
      {32'h40ae0000, 32'hbec00000}: return 32'hc1680000;
      {32'hc396d200, 32'hc0100000}: return 32'h43061000;
      {32'h3f800000, 32'h40000000}: return 32'h3f000000;
      {32'h40400000, 32'h3f800000}: return 32'h40400000;
      {32'h42c80000, 32'h41200000}: return 32'h41200000;
      default:                      return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  // Divider: busy for busy_len cycles after start; quotient is only valid in
  // the cycle busy falls, garbage otherwise. 'stuck' pins busy high.
  int unsigned  busy_len = 8;
  bit           stuck = 1'b0;
  int unsigned  dcnt = 0;
  bit           dfall = 1'b0;
  logic [W-1:0] dres = '0, da_s = '0, db_s = '0;

  always @(posedge clk) begin
    if (!rst) begin
      dcnt  <= 0;
      dfall <= 1'b0;
    end else begin
      dfall <= (dcnt == 1);
      if (dcnt != 0) dcnt <= dcnt - 1;
      else if (div_start) begin
        dcnt <= busy_len;
        dres <= div_model(div_a, div_b);
        da_s <= div_a;
        db_s <= div_b;
      end
    end
  end
  assign div_busy = stuck || (dcnt != 0);
  assign div_q    = dfall ? dres : 32'hDEADBEEF;

  // Checking infrastructure
  typedef struct packed {
    logic         id;
    logic [W-1:0] q;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0, acc_cyc = 0, lat = -1, n_rsp = 0;
  logic [1:0] rv_prev = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshake legality, latency capture, scoreboard pop.
  always @(negedge clk) begin
    if (rst) begin
      if (req_ready != 2'b00) begin
        check("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
        check("req_ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
        acc_cyc = cyc;
      end
      if (dcnt != 0) begin
        check("div_a_stable", 64'(div_a), 64'(da_s));
        check("div_b_stable", 64'(div_b), 64'(db_s));
      end
      if (rsp_valid != 2'b00 && rv_prev == 2'b00) lat = cyc - acc_cyc;
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_id", 64'(rsp_valid), mon_e.id ? 64'd2 : 64'd1);
          check("rsp_q", 64'(rsp_q), 64'(mon_e.q));
          check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        end
        n_rsp++;
      end
      rv_prev = rsp_valid;
    end else begin
      rv_prev = 2'b00;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int id);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
    end
    check("accept_seen", 64'(ok), 64'd1);
    step();
  endtask

  task automatic wait_any_accept(output int gid);
    bit ok = 1'b0;
    gid = -1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        ok  = 1'b1;
        gid = req_ready[1] ? 1 : 0;
      end
    end
    check("accept_seen", 64'(ok), 64'd1);
    step();
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int i = 0; i < budget && n_rsp < target; i++) @(negedge clk);
    @(negedge clk);
    check("rsp_count", 64'(n_rsp), 64'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  64'(req_ready),  64'd0);
    check({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    check({tag, "_rsp_q"},      64'(rsp_q),      64'd0);
    check({tag, "_rsp_err"},    64'(rsp_err),    64'd0);
    check({tag, "_div_a"},      64'(div_a),      64'd0);
    check({tag, "_div_b"},      64'(div_b),      64'd0);
    check({tag, "_div_start"},  64'(div_start),  64'd0);
    check({tag, "_div_enable"}, 64'(div_enable), 64'd0);
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int unsigned  busy;
    logic [W-1:0] q;
  } vec_t;

  vec_t vt[5];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int tgt, gid, hold_ok;
    logic [W-1:0] held_q;

    vt[0] = '{1'b0, 32'h40ae0000, 32'hbec00000, 8,  32'hc1680000};
    vt[1] = '{1'b1, 32'hc396d200, 32'hc0100000, 3,  32'h43061000};
    vt[2] = '{1'b0, 32'h3f800000, 32'h40000000, 1,  32'h3f000000};
    vt[3] = '{1'b0, 32'h40400000, 32'h3f800000, 15, 32'h40400000};
    vt[4] = '{1'b1, 32'h42c80000, 32'h41200000, 5,  32'h41200000};

    // Reset with requests pending: everything must read zero.
    rst       = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req0_a    = 32'h40ae0000;
    req0_b    = 32'hbec00000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    step();
    req_valid = 2'b00;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("enable_after_reset", 64'(div_enable), 64'd1);
    check("idle_no_ready", 64'(req_ready), 64'd0);

    // Tie straight after reset: requester 0 first.
    step();
    busy_len = 8;
    req0_a = 32'hc396d200; req0_b = 32'hc0100000;
    req1_a = 32'h40ae0000; req1_b = 32'hbec00000;
    sb.push_back('{id: 1'b0, q: 32'h43061000, err: 1'b0});
    sb.push_back('{id: 1'b1, q: 32'hc1680000, err: 1'b0});
    tgt = n_rsp + 2;
    req_valid = 2'b11;
    wait_accept(0);
    req_valid[0] = 1'b0;
    wait_accept(1);
    req_valid = 2'b00;
    wait_rsp(tgt, 200);

    // Single-request vectors with latency = 3 + busy duration.
    for (int i = 0; i < 5; i++) begin
      step();
      busy_len = vt[i].busy;
      if (vt[i].id) begin req1_a = vt[i].a; req1_b = vt[i].b; end
      else          begin req0_a = vt[i].a; req0_b = vt[i].b; end
      sb.push_back('{id: vt[i].id, q: vt[i].q, err: 1'b0});
      tgt = n_rsp + 1;
      req_valid[vt[i].id] = 1'b1;
      wait_accept(int'(vt[i].id));
      req_valid = 2'b00;
      wait_rsp(tgt, 100);
      check("latency", 64'(lat), 64'(3 + vt[i].busy));
    end

    // Fairness: both continuously valid, grants alternate 0,1,0,1,0,1.
    step();
    busy_len = 4;
    req0_a = 32'h40ae0000; req0_b = 32'hbec00000;
    req1_a = 32'hc396d200; req1_b = 32'hc0100000;
    for (int k = 0; k < 6; k++)
      sb.push_back('{id: k[0], q: k[0] ? 32'h43061000 : 32'hc1680000, err: 1'b0});
    tgt = n_rsp + 6;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_any_accept(gid);
      check("fair_grant", 64'(gid), 64'(k % 2));
    end
    req_valid = 2'b00;
    wait_rsp(tgt, 300);

    // Backpressure: requester 0 response held 5 cycles, requester 1 waiting
    // and asserting its own rsp_ready (which must be ignored).
    step();
    busy_len  = 3;
    rsp_ready = 2'b10;
    req0_a = 32'h3f800000; req0_b = 32'h40000000;
    req1_a = 32'h42c80000; req1_b = 32'h41200000;
    sb.push_back('{id: 1'b0, q: 32'h3f000000, err: 1'b0});
    sb.push_back('{id: 1'b1, q: 32'h41200000, err: 1'b0});
    tgt = n_rsp + 2;
    req_valid = 2'b01;
    wait_accept(0);
    req_valid = 2'b10;
    hold_ok = 0;
    for (int i = 0; i < 50 && hold_ok == 0; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) hold_ok = 1;
    end
    check("bp_rsp_seen", 64'(hold_ok), 64'd1);
    held_q = rsp_q;
    check("bp_first_q", 64'(held_q), 64'h3f000000);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_q", 64'(rsp_q), 64'(held_q));
      check("bp_hold_no_ready", 64'(req_ready), 64'd0);
    end
    step();
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_handshake_valid", 64'(rsp_valid), 64'd1);
    check("bp_handshake_no_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("bp_after_valid", 64'(rsp_valid), 64'd0);
    check("bp_next_accept", 64'(req_ready), 64'd2);
    step();
    req_valid = 2'b00;
    wait_rsp(tgt, 100);

    // Timeout: divider never finishes.
    step();
    stuck    = 1'b1;
    busy_len = 4;
    req1_a = 32'h40ae0000; req1_b = 32'hbec00000;
    sb.push_back('{id: 1'b1, q: '0, err: 1'b1});
    tgt = n_rsp + 1;
    req_valid = 2'b10;
    wait_accept(1);
    req_valid = 2'b00;
    @(negedge clk);
    check("issue_start", 64'(div_start), 64'd1);
    check("issue_div_a", 64'(div_a), 64'h40ae0000);
    @(negedge clk);
    check("wait_start_low", 64'(div_start), 64'd0);
    check("wait_div_b", 64'(div_b), 64'hbec00000);
    wait_rsp(tgt, 200);
    check("tmo_latency_range", 64'(lat >= 2 + TMO && lat <= 4 + TMO), 64'd1);
    step();
    stuck    = 1'b0;
    busy_len = 2;
    req0_a = 32'h3f800000; req0_b = 32'h40000000;
    sb.push_back('{id: 1'b0, q: 32'h3f000000, err: 1'b0});
    tgt = n_rsp + 1;
    req_valid = 2'b01;
    wait_accept(0);
    req_valid = 2'b00;
    wait_rsp(tgt, 100);

    // Reset mid-WAIT: no response, outputs zero, next tie goes to requester 0.
    step();
    busy_len = 20;
    req1_a = 32'hc396d200; req1_b = 32'hc0100000;
    req_valid = 2'b10;
    wait_accept(1);
    req_valid = 2'b00;
    repeat (5) step();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    step();
    rst = 1'b1;
    hold_ok = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) hold_ok = 0;
    end
    check("midrst_no_rsp", 64'(hold_ok), 64'd1);
    check("midrst_enable", 64'(div_enable), 64'd1);
    step();
    busy_len = 5;
    req0_a = 32'h40ae0000; req0_b = 32'hbec00000;
    req1_a = 32'h42c80000; req1_b = 32'h41200000;
    sb.push_back('{id: 1'b0, q: 32'hc1680000, err: 1'b0});
    sb.push_back('{id: 1'b1, q: 32'h41200000, err: 1'b0});
    tgt = n_rsp + 2;
    req_valid = 2'b11;
    wait_any_accept(gid);
    check("midrst_tie_grant", 64'(gid), 64'd0);
    req_valid[gid] = 1'b0;
    wait_any_accept(gid);
    req_valid = 2'b00;
    wait_rsp(tgt, 200);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fdiv_arbiter
`default_nettype wire

// File: doc/fdiv_arbiter.md
FDIV_ARBITER -- requirements
Module: fdiv_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter: WIDTH, 32, operand/result width (IEEE-754 single).
REQ-003 Parameter: TIMEOUT, 63, maximum WAIT cycles before abort.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  2  per-requester request valid; bit0 = requester 0.
REQ-007 req_ready  out  2  per-requester accept; one-hot or zero.
REQ-008 req0_a  in  WIDTH  requester 0 dividend.
REQ-009 req0_b  in  WIDTH  requester 0 divisor.
REQ-010 req1_a  in  WIDTH  requester 1 dividend.
REQ-011 req1_b  in  WIDTH  requester 1 divisor.
REQ-012 rsp_valid  out  2  per-requester response valid; one-hot or zero.
REQ-013 rsp_ready  in  2  per-requester response accept.
REQ-014 rsp_q  out  WIDTH  quotient, shared by both requesters.
REQ-015 rsp_err  out  1  response is a timeout abort.
REQ-016 div_a  out  WIDTH  divider dividend.
REQ-017 div_b  out  WIDTH  divider divisor.
REQ-018 div_start  out  1  divider start.
REQ-019 div_enable  out  1  divider enable.
REQ-020 div_q  in  WIDTH  divider quotient; valid in the cycle div_busy falls.
REQ-021 div_busy  in  1  divider computing.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-023 IDLE: if any req_valid is set, the FSM SHALL pick one requester and assert its req_ready for exactly that cycle.
REQ-024 In that IDLE accept cycle, the FSM SHALL latch the picked requester's operands and id, then go to ISSUE.
REQ-025 Pick rule: a single valid requester SHALL win; when both are valid, the requester not served last SHALL win (round-robin pointer last_id).
REQ-026 req_ready SHALL be 0 in every state other than IDLE; requests arriving then are held off, not dropped.
REQ-027 ISSUE: div_a/div_b SHALL show the latched operands and div_start SHALL be 1.
REQ-028 ISSUE SHALL hold div_start until div_busy=1 is sampled, then go to WAIT with div_start=0 from the next cycle.
REQ-029 div_a/div_b SHALL stay stable from ISSUE through WAIT.
REQ-030 WAIT: a cycle counter SHALL start at 0 and increment each cycle.
REQ-031 WAIT: when div_busy=0, the FSM SHALL latch div_q into rsp_q, set rsp_err=0 and go to RESP.
REQ-032 WAIT: if the counter reaches TIMEOUT while div_busy=1, the FSM SHALL set rsp_q=0 and rsp_err=1, then go to RESP.
REQ-033 If div_busy falls in the same cycle the counter reaches TIMEOUT, the normal result SHALL win.
REQ-034 RESP: rsp_valid[id] SHALL be 1 and rsp_q/rsp_err SHALL be held stable until rsp_ready[id]=1.
REQ-035 On the RESP handshake, last_id SHALL be set to id and the FSM SHALL go to IDLE; rsp_ready of the other requester SHALL be ignored.
REQ-036 A new request SHALL be accepted no earlier than the cycle after the RESP handshake.
REQ-037 Minimum latency, accept to rsp_valid: 3 cycles plus divider busy duration.
REQ-038 div_enable SHALL be 1 whenever rst=1.

Reset
REQ-039 While rst=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-040 While rst=0, all outputs SHALL be 0, including req_ready, rsp_valid, rsp_q, rsp_err, div_a, div_b, div_start and div_enable.
REQ-041 Reset SHALL set last_id=1, so requester 0 wins the first tie.
REQ-042 Reset SHALL clear the counter.
REQ-043 Reset mid-operation SHALL abandon the in-flight division with no response issued.

Structure
REQ-044 Package fdiv_pkg SHALL hold the state enum, the requester-id type (1 bit) and the WIDTH default.
REQ-045 The two-way round-robin pick SHALL be sub-module fdiv_rr2: inputs valid[1:0] and last_id, outputs grant one-hot and gid.
REQ-046 The FSM, counter and latches SHALL be inline.

Verification
REQ-047 Single request: req0 a=40ae0000, b=bec00000; divider model busy 8 cycles -> rsp_valid=01, rsp_q=c1680000, rsp_err=0.
REQ-048 Tie after reset: both valid; req0 c396d200/c0100000, req1 40ae0000/bec00000 -> req0 served first (43061000), then req1 (c1680000).
REQ-049 Fairness: both requesters continuously valid for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-050 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_q stable, req_ready=00 throughout, handshake completes on first rsp_ready=1.
REQ-051 Timeout: div_busy stuck at 1 -> after 63 WAIT cycles rsp_err=1 and rsp_q=0; the next request is then served normally.
REQ-052 Reset mid-WAIT: rst=0 for 1 cycle -> all outputs 0, no rsp_valid, and the next tie grants req0.
